// File: rtl/alu_pkg.sv
// Shared opcode, instruction-field and flag definitions for the ALU issue/writeback stage.
package alu_pkg;

   localparam logic [3:0] OP_XOR = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_ADD = 4'b0101;
   localparam logic [3:0] OP_LDI = 4'b1000;

   localparam int OP_LSB  = 12;
   localparam int RD_LSB  = 9;
   localparam int RS1_LSB = 6;
   localparam int RS2_LSB = 3;
   localparam int IMM_W   = 9;

   localparam int FLAG_ZERO       = 0;
   localparam int FLAG_CARRY      = 1;
   localparam int FLAG_OVERFLOW   = 2;
   localparam int FLAG_NEGATIVE   = 3;
   localparam int FLAG_ODD_PARITY = 4;
   localparam int FLAG_W          = 5;

   function automatic logic is_alu_op(input logic [3:0] op);
      return (op == OP_XOR) || (op == OP_AND) || (op == OP_OR) ||
             (op == OP_SUB) || (op == OP_ADD);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two asynchronous operand read ports, one debug read port, one synchronous write.
// Register 0 is never written and always reads as zero.
module alu_regfile
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREGS  = 8,
   parameter int ADDR_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata
);

   logic [DATA_W-1:0] regs [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   // Address 0 is forced to zero on read so r0 stays zero regardless of array contents.
   assign rdata1   = (raddr1   == '0) ? '0 : regs[raddr1];
   assign rdata2   = (raddr2   == '0) ? '0 : regs[raddr2];
   assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage: decodes instructions, reads and forwards operands into a registered
// EX stage feeding the external ALU, and commits results, flags and the retired count.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREGS  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [15:0]               in_instr,
   input  logic                      stall,
   output logic [3:0]                alu_op,
   output logic [DATA_W-1:0]         alu_a,
   output logic [DATA_W-1:0]         alu_b,
   input  logic [DATA_W-1:0]         alu_out,
   input  logic                      alu_zero,
   input  logic                      alu_carry,
   input  logic                      alu_overflow,
   input  logic                      alu_negative,
   input  logic                      alu_odd_parity,
   output logic [FLAG_W-1:0]         flags,
   output logic                      commit_valid,
   output logic [CNT_W-1:0]          retired,
   input  logic [$clog2(NREGS)-1:0]  dbg_addr,
   output logic [DATA_W-1:0]         dbg_data
);

   localparam int ADDR_W = $clog2(NREGS);

   logic [3:0]        in_op;
   logic [ADDR_W-1:0] in_rd, in_rs1, in_rs2;
   logic [IMM_W-1:0]  in_imm;
   logic [DATA_W-1:0] rf_rdata1, rf_rdata2;
   logic [DATA_W-1:0] opa_next, opb_next;

   logic              ex_valid_reg;
   logic [3:0]        ex_op_reg;
   logic [ADDR_W-1:0] ex_rd_reg;
   logic [IMM_W-1:0]  ex_imm_reg;
   logic [DATA_W-1:0] alu_a_reg, alu_b_reg;
   logic [FLAG_W-1:0] flags_reg, flags_next;
   logic              commit_valid_reg;
   logic [CNT_W-1:0]  retired_reg;

   logic              ex_is_alu, ex_is_ldi, ex_writes, commit;
   logic [DATA_W-1:0] ex_result;

   assign in_op  = in_instr[OP_LSB +: 4];
   assign in_rd  = in_instr[RD_LSB +: ADDR_W];
   assign in_rs1 = in_instr[RS1_LSB +: ADDR_W];
   assign in_rs2 = in_instr[RS2_LSB +: ADDR_W];
   assign in_imm = in_instr[IMM_W-1:0];

   assign in_ready  = !rst && !stall;
   assign ex_is_alu = is_alu_op(ex_op_reg);
   assign ex_is_ldi = (ex_op_reg == OP_LDI);
   // ex_rd != 0 also keeps r0 out of forwarding, so a source of r0 always reads zero.
   assign ex_writes = ex_valid_reg && (ex_is_alu || ex_is_ldi) && (ex_rd_reg != '0);
   assign ex_result = ex_is_ldi ? {{(DATA_W-IMM_W){1'b0}}, ex_imm_reg} : alu_out;
   assign commit    = ex_valid_reg && !stall;

   assign opa_next = (ex_writes && (ex_rd_reg == in_rs1)) ? ex_result : rf_rdata1;
   assign opb_next = (ex_writes && (ex_rd_reg == in_rs2)) ? ex_result : rf_rdata2;

   alu_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .raddr1   (in_rs1),
      .raddr2   (in_rs2),
      .rdata1   (rf_rdata1),
      .rdata2   (rf_rdata2),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .we       (commit && ex_writes),
      .waddr    (ex_rd_reg),
      .wdata    (ex_result)
   );

   always_comb begin
      flags_next                  = '0;
      flags_next[FLAG_ZERO]       = alu_zero;
      flags_next[FLAG_CARRY]      = alu_carry;
      flags_next[FLAG_OVERFLOW]   = alu_overflow;
      flags_next[FLAG_NEGATIVE]   = alu_negative;
      flags_next[FLAG_ODD_PARITY] = alu_odd_parity;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_reg     <= 1'b0;
         ex_op_reg        <= '0;
         ex_rd_reg        <= '0;
         ex_imm_reg       <= '0;
         alu_a_reg        <= '0;
         alu_b_reg        <= '0;
         flags_reg        <= '0;
         commit_valid_reg <= 1'b0;
         retired_reg      <= '0;
      end else begin
         if (!stall) begin
            ex_valid_reg <= in_valid && in_ready;
            ex_op_reg    <= in_op;
            ex_rd_reg    <= in_rd;
            ex_imm_reg   <= in_imm;
            alu_a_reg    <= opa_next;
            alu_b_reg    <= opb_next;
         end
         commit_valid_reg <= commit;
         if (commit) begin
            retired_reg <= retired_reg + CNT_W'(1);
         end
         if (commit && ex_is_alu) begin
            flags_reg <= flags_next;
         end
      end
   end

   assign alu_op       = ex_op_reg;
   assign alu_a        = alu_a_reg;
   assign alu_b        = alu_b_reg;
   assign flags        = flags_reg;
   assign commit_valid = commit_valid_reg;
   assign retired      = retired_reg;

endmodule
